// File: rtl/irq_ctrl.sv
// Priority interrupt controller: edge capture into PENDING, ENABLE masking, req/ack/eoi handshake.
// Define IRQ_CTRL_SYNC_EN to add a two-flop synchronizer on every src bit (latency 2 -> 4 cycles).
module irq_ctrl #(
  parameter int NUM_SRC = 8,
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               in_service,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] src_s, src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_v, elig, clr;
  logic [ID_W-1:0]    cand;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end
  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  generate
    if (NUM_SRC < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^reg_wdata[31:NUM_SRC];
    end
  endgenerate

  always_comb begin
    edge_v   = src_s & ~src_q;
    elig     = pending_q & enable_q;
    cand     = '0;
    // Descending scan so the lowest set index is the one that sticks.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) cand = ID_W'(i);
    end
    enable_d = enable_q;
    clr      = '0;
    state_d  = state_q;
    id_d     = id_q;
    if (reg_we && reg_addr == 2'd0) enable_d = reg_wdata[NUM_SRC-1:0];
    if (reg_we && reg_addr == 2'd1) clr = reg_wdata[NUM_SRC-1:0];
    case (state_q)
      IDLE: begin
        if (|elig) begin
          id_d    = cand;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack beats withdrawal when both happen in the same cycle.
        if (irq_ack) begin
          clr[id_q] = 1'b1;
          state_d   = SERVICE;
        end else if (!elig[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new edge overrides any clear of the same bit.
    pending_d = (pending_q & ~clr) | edge_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      src_q     <= src_s;
      pending_q <= pending_d;
      enable_q  <= enable_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = id_q;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0: reg_rdata[NUM_SRC-1:0] = enable_q;
      2'd1: reg_rdata[NUM_SRC-1:0] = pending_q;
      2'd2: begin
        reg_rdata[31]       = in_service;
        reg_rdata[30]       = irq_req;
        reg_rdata[ID_W-1:0] = id_q;
      end
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected ids queued when sources fire, checked when irq_req rises.
module tb_irq_ctrl;
  localparam int NUM_SRC = 8;
  localparam int ID_W = 3;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] src;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               eoi;
  logic               in_service;
  logic               reg_we;
  logic [1:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk(clk), .rst(rst), .src(src), .irq_req(irq_req), .irq_id(irq_id),
    .irq_ack(irq_ack), .eoi(eoi), .in_service(in_service), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    checks++;
    if (reg_rdata !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, reg_rdata, exp);
    end
  endtask

  task automatic pulse_src(input logic [NUM_SRC-1:0] m);
    src = m;
    tick();
    src = '0;
  endtask

  // Ticks n times; irq_req must stay low until the last tick, then pop and match irq_id.
  task automatic expect_req(input string name, input int n);
    int exp_id;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (irq_req !== 1'b0) begin
        errors++;
        $display("FAIL %s early: irq_req=%b expected 0 at step %0d", name, irq_req, i);
      end
      tick();
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, irq_req=%b", name, irq_req);
    end else begin
      exp_id = exp_q.pop_front();
      if (irq_req !== 1'b1 || irq_id !== ID_W'(exp_id)) begin
        errors++;
        $display("FAIL %s: irq_req=%b irq_id=%0d expected req=1 id=%0d", name, irq_req, irq_id, exp_id);
      end
    end
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src = '0; irq_ack = 0; eoi = 0; reg_we = 0; reg_addr = 0; reg_wdata = 0;
    tick(); tick();
    checks++;
    if (irq_req !== 1'b0 || irq_id !== '0 || in_service !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b id=%0d isvc=%b expected 0 0 0", irq_req, irq_id, in_service);
    end
    for (int a = 0; a < 4; a++) read_chk("reset_regs", 2'(a), 32'h0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    reg_write(2'd0, 32'h01);
    read_chk("enable_rb", 2'd0, 32'h01);
    exp_q.push_back(0);
    pulse_src(8'h01);
    expect_req("basic_req", LAT - 1);
    read_chk("basic_status_req", 2'd2, 32'h4000_0000);
    do_ack();
    checks++;
    if (in_service !== 1'b1 || irq_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: isvc=%b req=%b expected 1 0", in_service, irq_req);
    end
    read_chk("basic_pending", 2'd1, 32'h0);
    read_chk("basic_status_svc", 2'd2, 32'h8000_0000);
    do_eoi();
    read_chk("basic_status_eoi", 2'd2, 32'h0);
  endtask

  task automatic test_priority();
    reg_write(2'd0, 32'hFF);
    exp_q.push_back(2);
    exp_q.push_back(5);
    pulse_src(8'h24);
    expect_req("prio_first", LAT - 1);
    do_ack();
    read_chk("prio_pending", 2'd1, 32'h20);
    do_eoi();
    expect_req("prio_back_to_back", 1);
    do_ack();
    do_eoi();
  endtask

  task automatic test_hold_id();
    exp_q.push_back(3);
    pulse_src(8'h08);
    expect_req("hold_first", LAT - 1);
    exp_q.push_back(1);
    pulse_src(8'h02);
    tick(); tick(); tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd3) begin
      errors++;
      $display("FAIL hold_stable: req=%b id=%0d expected 1 3", irq_req, irq_id);
    end
    do_ack();
    do_eoi();
    expect_req("hold_next", 1);
    do_ack();
    do_eoi();
  endtask

  task automatic test_masked();
    reg_write(2'd0, 32'h00);
    pulse_src(8'h10);
    for (int i = 0; i < LAT; i++) tick();
    read_chk("masked_pending", 2'd1, 32'h10);
    checks++;
    if (irq_req !== 1'b0) begin
      errors++;
      $display("FAIL masked_noreq: irq_req=%b expected 0", irq_req);
    end
    exp_q.push_back(4);
    reg_write(2'd0, 32'h10);
    expect_req("masked_enable", 1);
    do_ack();
    do_eoi();
    read_chk("masked_clean", 2'd1, 32'h0);
  endtask

  task automatic test_withdraw_reset();
    reg_write(2'd0, 32'hFF);
    exp_q.push_back(6);
    pulse_src(8'h40);
    expect_req("wd_req", LAT - 1);
    reg_write(2'd1, 32'h40);
    tick();
    checks++;
    if (irq_req !== 1'b0 || in_service !== 1'b0) begin
      errors++;
      $display("FAIL wd_drop: req=%b isvc=%b expected 0 0", irq_req, in_service);
    end
    read_chk("wd_pending", 2'd1, 32'h0);
    exp_q.push_back(3);
    pulse_src(8'h48);
    expect_req("rst_req", LAT - 1);
    do_ack();
    read_chk("rst_pre_pending", 2'd1, 32'h40);
    rst = 1'b1;
    #1;
    checks++;
    if (irq_req !== 1'b0 || in_service !== 1'b0 || irq_id !== '0) begin
      errors++;
      $display("FAIL rst_async: req=%b isvc=%b id=%0d expected 0 0 0", irq_req, in_service, irq_id);
    end
    read_chk("rst_pending", 2'd1, 32'h0);
    read_chk("rst_enable", 2'd0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sustain();
    src = 8'h80;
    for (int i = 0; i < 10; i++) tick();
    read_chk("sus_once", 2'd1, 32'h80);
    reg_write(2'd1, 32'h80);
    tick(); tick();
    read_chk("sus_no_reset", 2'd1, 32'h0);
    src = '0;
    for (int i = 0; i < LAT; i++) tick();
    src = 8'h80;
    for (int i = 0; i < LAT - 2; i++) tick();
    reg_write(2'd1, 32'h80);
    read_chk("sus_set_wins", 2'd1, 32'h80);
    checks++;
    if (irq_req !== 1'b0) begin
      errors++;
      $display("FAIL sus_masked_req: irq_req=%b expected 0", irq_req);
    end
    src = '0;
    reg_write(2'd1, 32'h80);
    read_chk("sus_cleared", 2'd1, 32'h0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_hold_id();
    test_masked();
    test_withdraw_reset();
    test_sustain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Interrupt controller directly downstream of the system timer and other peripheral interrupt sources. Captures rising edges on NUM_SRC request lines into a pending register and masks them with a software enable register. Selects the highest-priority source and presents it to the CPU through a req/ack/eoi handshake. Source 0 is wired to the timer irq pulse. Lower index means higher priority.

Parameters:
NUM_SRC, 8, number of interrupt source lines (1..32)
ID_W, $clog2(NUM_SRC) (min 1), derived localparam, width of irq_id

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous and active-high; all state cleared immediately on assertion
src  in  NUM_SRC  interrupt sources; bit i pulses or levels high; edge-sensitive
irq_req  out  1  interrupt request to the CPU
irq_id  out  ID_W  index of the requested source; valid while irq_req=1
irq_ack  in  1  CPU accepts the request (1-cycle pulse)
eoi  in  1  end-of-interrupt from the CPU (1-cycle pulse)
in_service  out  1  high from ack until eoi
reg_we  in  1  register write strobe
reg_addr  in  2  register select
reg_wdata  in  32  write data
reg_rdata  out  32  combinational read data for reg_addr

Behaviour:
- Registers:
  - addr 0 ENABLE: RW; bits [NUM_SRC-1:0]; reset 0.
  - addr 1 PENDING: read returns pending; writing 1 to a bit clears that bit (W1C).
  - addr 2 STATUS: RO; {in_service at bit 31, irq_req at bit 30, zeros, irq_id in low ID_W bits}.
  - addr 3: reads 0; writes ignored.
  - Unused upper bits read 0.
- Edge detect: src_q <= src every cycle (reset 0). Edge vector is src & ~src_q.
  - A sustained-high source sets pending only once.
  - It must fall and rise again to set pending again.
- Pending set/clear:
  - pending[i] is set after the edge where edge[i]=1.
  - It is cleared by a W1C write or by an ack for id i.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Masked sources still latch pending; they are eligible once enabled.
- Eligible vector = pending & enable. Candidate = lowest set index.
- FSM (reset state IDLE):
  - IDLE:
    - If eligible != 0, latch irq_id = candidate and go to REQ.
    - ack and eoi are ignored in this state.
  - REQ:
    - irq_req=1; irq_id is held stable even if a higher-priority source becomes pending.
    - On irq_ack: clear pending[irq_id], set in_service, go to SERVICE.
    - Withdrawal: if eligible[irq_id] drops (masked or W1C) before ack, drop irq_req next cycle and return to IDLE. A simultaneous ack takes precedence over withdrawal.
    - eoi is ignored in this state.
  - SERVICE:
    - irq_req=0; in_service=1; no new request is raised (no nesting).
    - On eoi: clear in_service and go to IDLE. Re-arbitration happens in IDLE on the following cycle.
    - ack is ignored in this state.
- Latency: src rises in cycle 0 (sampled at edge 1) -> pending set after edge 1 -> irq_req=1 after edge 2, i.e. 2 cycles.
- Back-to-back: after eoi, the next eligible source raises irq_req 2 cycles later (IDLE then REQ).
- Reset values: irq_req=0, irq_id=0, in_service=0, reg_rdata follows the cleared registers. Reset mid-handshake abandons the request; no ack/eoi is required afterwards.
- Writes: a register write and an FSM update in the same cycle both take effect.
  - ENABLE changes are visible to arbitration the next cycle.

Optional Feature:
Macro IRQ_CTRL_SYNC_EN.
- Defined: each src bit passes through a two-flop synchronizer (reset 0) before edge detection. Latency src->irq_req becomes 4 cycles.
- Undefined: src is used directly (synchronous sources only); latency is 2 cycles.
- Register map and handshake are identical in both builds.

Test Plan:
- Reset, ENABLE=0x01, src[0] 1-cycle pulse at cycle 0 -> irq_req=1 after edge 2 with irq_id=0. ack -> PENDING=0, in_service=1. eoi -> STATUS=0.
- ENABLE=0xFF, src[5] and src[2] rise in the same cycle -> irq_id=2 first. After ack+eoi, irq_id=5 is raised 2 cycles later.
- In REQ with irq_id=3, src[1] rises -> irq_id stays 3 until ack. After eoi, irq_id=1 is requested.
- ENABLE=0x00, src[4] pulse -> PENDING=0x10 and irq_req=0. Write ENABLE=0x10 -> irq_req=1 with irq_id=4 one cycle later.
- In REQ for id 6, W1C write PENDING=0x40 -> irq_req=0 next cycle, FSM back to IDLE. Assert rst during SERVICE -> all outputs 0 and PENDING=0.
- Hold src[7] high 10 cycles -> single pending event. W1C in the same cycle as a new src[7] edge -> pending stays 1.
